// File: rtl/ipsxe_floating_point_fl2fx_top_v1_0.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ipsxe_floating_point_fl2fx_top_v1_0
//  Description : Floating-point to fixed-point converter. Five-stage pipeline
//                with clock enable, round-to-nearest-even, saturation on
//                overflow, NaN reported as invalid.
//  Revision    : 1.0  initial release
// ============================================================================
module ipsxe_floating_point_fl2fx_top_v1_0 #(
    parameter int FIXED_INT_BIT  = 32,
    parameter int FIXED_FRAC_BIT = 0,
    parameter int FLOAT_EXP_BIT  = 8,
    parameter int FLOAT_FRAC_BIT = 24,
    parameter int INT_TYPE       = 0
) (
    input  logic                                    i_aclk,
    input  logic                                    i_areset_n,
    input  logic                                    i_aclken,
    input  logic [FLOAT_EXP_BIT+FLOAT_FRAC_BIT-1:0] i_axi4s_a_tdata,
    input  logic                                    i_axi4s_or_abcoperation_tvalid,
    output logic [FIXED_INT_BIT+FIXED_FRAC_BIT-1:0] o_axi4s_result_tdata,
    output logic                                    o_axi4s_result_tvalid,
    output logic                                    o_overflow,
    output logic                                    o_invalid
);

    // Result width, mantissa width (hidden one included), stored fraction width
    localparam int DW  = FIXED_INT_BIT + FIXED_FRAC_BIT;
    localparam int FF  = FLOAT_FRAC_BIT;
    localparam int FW  = FLOAT_FRAC_BIT - 1;
    localparam int IW  = FLOAT_EXP_BIT + FLOAT_FRAC_BIT;
    // Working register: integer field, guard, round, sticky source bits
    localparam int W   = DW + FF + 1;
    localparam int SHW = $clog2(W);
    // Exponent arithmetic is FLOAT_EXP_BIT+2 bits wide, widened further so the
    // shift amount (E + FIXED_FRAC_BIT) can never wrap.
    localparam int SW  = FLOAT_EXP_BIT + 2 + SHW;

    localparam logic signed [SW-1:0] BIAS_S    = SW'((2 ** (FLOAT_EXP_BIT-1)) - 1);
    localparam logic signed [SW-1:0] INT_LIM_S = SW'(FIXED_INT_BIT);
    localparam logic signed [SW-1:0] FRAC_S    = SW'(FIXED_FRAC_BIT);
    localparam logic signed [SW-1:0] TWO_S     = SW'(2);
    localparam logic signed [SW-1:0] ONE_S     = SW'(1);
    localparam logic [DW-1:0]        ONE_DW    = DW'(1);
    localparam logic [DW-1:0]        MAX_POS   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        MIN_NEG   = {1'b1, {(DW-1){1'b0}}};
    localparam bit                   SIGNED_OUT = (INT_TYPE == 0);

    // ------------------------------------------------------------------
    // Stage 1: field split and classification
    // ------------------------------------------------------------------
    logic                     in_sign;
    logic [FLOAT_EXP_BIT-1:0] in_exp;
    logic [FW-1:0]            in_frac;

    assign in_sign = i_axi4s_a_tdata[IW-1];
    assign in_exp  = i_axi4s_a_tdata[IW-2 -: FLOAT_EXP_BIT];
    assign in_frac = i_axi4s_a_tdata[FW-1:0];

    logic                     s1_sign, s1_zero, s1_nan, s1_inf;
    logic [FLOAT_EXP_BIT-1:0] s1_exp;
    logic [FW-1:0]            s1_frac;

    // Register the operand fields and its special-value class
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_frac <= '0;
            s1_zero <= 1'b0;
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
        end else if (i_aclken) begin
            s1_sign <= in_sign;
            s1_exp  <= in_exp;
            s1_frac <= in_frac;
            s1_zero <= (in_exp == '0);
            s1_nan  <= (&in_exp) && (in_frac != '0);
            s1_inf  <= (&in_exp) && (in_frac == '0);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: unbias exponent, derive shift, predict overflow/underflow
    // ------------------------------------------------------------------
    logic signed [SW-1:0] unbiased, shift, shamt_full;
    logic                 ovf_pred, underflow;
    logic [SHW-1:0]       shamt;
    logic [SW-SHW-1:0]    unused_shamt_hi;

    // Shift is measured so that the mantissa LSB lands at bit (shift+2) of the
    // working register. Only E >= FIXED_INT_BIT is flagged here; the signed
    // boundary E == FIXED_INT_BIT-1 is resolved on the rounded magnitude so that
    // the most negative value and round-down cases stay legal.
    always_comb begin
        unbiased   = $signed({{(SW-FLOAT_EXP_BIT){1'b0}}, s1_exp}) - BIAS_S;
        shift      = unbiased + FRAC_S;
        shamt_full = shift + TWO_S;
        ovf_pred   = (unbiased >= INT_LIM_S);
        underflow  = (shamt_full < ONE_S);
    end

    assign shamt           = shamt_full[SHW-1:0];
    assign unused_shamt_hi = shamt_full[SW-1:SHW];

    logic           s2_sign, s2_zero, s2_ovf, s2_nan, s2_inf;
    logic [FW-1:0]  s2_frac;
    logic [SHW-1:0] s2_shamt;

    // Register shift amount and the early-decided cases
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            s2_sign  <= 1'b0;
            s2_frac  <= '0;
            s2_shamt <= '0;
            s2_zero  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_nan   <= 1'b0;
            s2_inf   <= 1'b0;
        end else if (i_aclken) begin
            s2_sign  <= s1_sign;
            s2_frac  <= s1_frac;
            s2_shamt <= shamt;
            s2_zero  <= s1_zero | underflow;
            s2_ovf   <= ovf_pred & ~s1_zero;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: barrel shift, extract integer field, guard, round, sticky
    // ------------------------------------------------------------------
    logic [W-1:0] work;

    // Align the mantissa; early-decided samples produce an all-zero field
    always_comb begin
        work = {{(W-FF){1'b0}}, 1'b1, s2_frac} << s2_shamt;
        if (s2_zero || s2_ovf) begin
            work = '0;
        end
    end

    logic          s3_sign, s3_ovf, s3_nan, s3_inf, s3_g, s3_r, s3_s;
    logic [DW-1:0] s3_int;

    // Register the truncated magnitude and rounding bits
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            s3_sign <= 1'b0;
            s3_int  <= '0;
            s3_g    <= 1'b0;
            s3_r    <= 1'b0;
            s3_s    <= 1'b0;
            s3_ovf  <= 1'b0;
            s3_nan  <= 1'b0;
            s3_inf  <= 1'b0;
        end else if (i_aclken) begin
            s3_sign <= s2_sign;
            s3_int  <= work[W-1:FF+1];
            s3_g    <= work[FF];
            s3_r    <= work[FF-1];
            s3_s    <= |work[FF-2:0];
            s3_ovf  <= s2_ovf;
            s3_nan  <= s2_nan;
            s3_inf  <= s2_inf;
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: round to nearest even, magnitude range check
    // ------------------------------------------------------------------
    logic          round_up, mag_ovf;
    logic [DW:0]   mag_r;

    // Signed results allow a magnitude of exactly 2^(DW-1) only when negative
    always_comb begin
        round_up = s3_g & (s3_r | s3_s | s3_int[0]);
        mag_r    = {1'b0, s3_int} + {{DW{1'b0}}, round_up};
        if (SIGNED_OUT) begin
            mag_ovf = mag_r[DW] | (mag_r[DW-1] & (~s3_sign | (|mag_r[DW-2:0])));
        end else begin
            mag_ovf = mag_r[DW];
        end
    end

    logic          s4_sign, s4_ovf, s4_nan, s4_inf;
    logic [DW-1:0] s4_mag;

    // Register the rounded magnitude and accumulated overflow
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            s4_sign <= 1'b0;
            s4_mag  <= '0;
            s4_ovf  <= 1'b0;
            s4_nan  <= 1'b0;
            s4_inf  <= 1'b0;
        end else if (i_aclken) begin
            s4_sign <= s3_sign;
            s4_mag  <= mag_r[DW-1:0];
            s4_ovf  <= s3_ovf | mag_ovf;
            s4_nan  <= s3_nan;
            s4_inf  <= s3_inf;
        end
    end

    // ------------------------------------------------------------------
    // Stage 5: apply sign, saturate, register outputs
    // ------------------------------------------------------------------
    logic [DW-1:0] res_n;
    logic          ovf_n, inv_n;

    // Priority: NaN, then saturation, then unsigned-negative clamp, else value
    always_comb begin
        res_n = s4_sign ? ((~s4_mag) + ONE_DW) : s4_mag;
        ovf_n = 1'b0;
        inv_n = 1'b0;
        if (s4_nan) begin
            res_n = SIGNED_OUT ? MIN_NEG : '0;
            inv_n = 1'b1;
        end else if (s4_inf || s4_ovf) begin
            if (SIGNED_OUT) begin
                res_n = s4_sign ? MIN_NEG : MAX_POS;
            end else begin
                res_n = s4_sign ? '0 : '1;
            end
            ovf_n = 1'b1;
        end else if (!SIGNED_OUT && s4_sign) begin
            res_n = '0;
            ovf_n = |s4_mag;
        end
    end

    logic [4:0] vld_pipe;

    // Output registers and the valid delay chain share the same enable
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_axi4s_result_tdata <= '0;
            o_overflow           <= 1'b0;
            o_invalid            <= 1'b0;
            vld_pipe             <= '0;
        end else if (i_aclken) begin
            o_axi4s_result_tdata <= res_n;
            o_overflow           <= ovf_n;
            o_invalid            <= inv_n;
            vld_pipe             <= {vld_pipe[3:0], i_axi4s_or_abcoperation_tvalid};
        end
    end

    assign o_axi4s_result_tvalid = vld_pipe[4];

endmodule
`default_nettype wire

// File: tb/tb_ipsxe_floating_point_fl2fx_top_v1_0.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ipsxe_floating_point_fl2fx_top_v1_0
//  Description : Scoreboard bench for the float-to-fixed converter. Instance 0
//                is float32 -> signed int32, instance 1 is float32 -> unsigned
//                Q24.8.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ipsxe_floating_point_fl2fx_top_v1_0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [31:0] a0, a1;
    logic        v0, v1;
    logic [31:0] res0, res1;
    logic        vld0, vld1, ovf0, ovf1, inv0, inv1;

    always #5 clk = ~clk;

    ipsxe_floating_point_fl2fx_top_v1_0 dut0 (
        .i_aclk                         (clk),
        .i_areset_n                     (rst_n),
        .i_aclken                       (en),
        .i_axi4s_a_tdata                (a0),
        .i_axi4s_or_abcoperation_tvalid (v0),
        .o_axi4s_result_tdata           (res0),
        .o_axi4s_result_tvalid          (vld0),
        .o_overflow                     (ovf0),
        .o_invalid                      (inv0)
    );

    ipsxe_floating_point_fl2fx_top_v1_0 #(
        .FIXED_INT_BIT  (24),
        .FIXED_FRAC_BIT (8),
        .INT_TYPE       (1)
    ) dut1 (
        .i_aclk                         (clk),
        .i_areset_n                     (rst_n),
        .i_aclken                       (en),
        .i_axi4s_a_tdata                (a1),
        .i_axi4s_or_abcoperation_tvalid (v1),
        .o_axi4s_result_tdata           (res1),
        .o_axi4s_result_tvalid          (vld1),
        .o_overflow                     (ovf1),
        .o_invalid                      (inv1)
    );

    typedef struct {
        logic [31:0] d;
        logic        ovf;
        logic        inv;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          en_edges = 0;
    bit          edge_en = 1'b0;
    logic [33:0] held0 = '0;
    logic [33:0] held1 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // Count enabled, out-of-reset clock edges (latency reference)
    always @(posedge clk) begin
        edge_en = en && rst_n;
        if (edge_en) en_edges++;
    end

    // Monitor for instance 0
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && vld0) begin
            if (edge_en) begin
                if (q0.size() == 0) begin
                    flag_fail("dut0_unexpected_valid", {30'd0, res0, ovf0, inv0});
                end else begin
                    e = q0.pop_front();
                    chk("dut0_result", {30'd0, res0, ovf0, inv0}, {30'd0, e.d, e.ovf, e.inv});
                    chk("dut0_latency", 64'(en_edges), 64'(e.due));
                    held0 = {res0, ovf0, inv0};
                end
            end else begin
                chk("dut0_stall_hold", {30'd0, res0, ovf0, inv0}, {30'd0, held0});
            end
        end
    end

    // Monitor for instance 1
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && vld1) begin
            if (edge_en) begin
                if (q1.size() == 0) begin
                    flag_fail("dut1_unexpected_valid", {30'd0, res1, ovf1, inv1});
                end else begin
                    e = q1.pop_front();
                    chk("dut1_result", {30'd0, res1, ovf1, inv1}, {30'd0, e.d, e.ovf, e.inv});
                    chk("dut1_latency", 64'(en_edges), 64'(e.due));
                    held1 = {res1, ovf1, inv1};
                end
            end else begin
                chk("dut1_stall_hold", {30'd0, res1, ovf1, inv1}, {30'd0, held1});
            end
        end
    end

    // Drive one sample into the chosen instance and push its expected response
    task automatic send(input int which, input logic [31:0] a, input logic [31:0] d,
                        input logic o, input logic i);
        exp_t e;
        @(negedge clk);
        v0    = 1'b0;
        v1    = 1'b0;
        e.d   = d;
        e.ovf = o;
        e.inv = i;
        e.due = en_edges + 5;
        if (which == 0) begin
            a0 = a;
            v0 = 1'b1;
            q0.push_back(e);
        end else begin
            a1 = a;
            v1 = 1'b1;
            q1.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v0 = 1'b0;
            v1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int stale;
        a0 = '0;
        a1 = '0;
        v0 = 1'b0;
        v1 = 1'b0;
        #3;
        chk("reset_outputs_dut0", {29'd0, res0, vld0, ovf0, inv0}, 64'd0);
        chk("reset_outputs_dut1", {29'd0, res1, vld1, ovf1, inv1}, 64'd0);
        idle(2);
        rst_n = 1'b1;

        // Signed int32 directed vectors
        send(0, 32'h3F800000, 32'h00000001, 1'b0, 1'b0); // 1.0
        send(0, 32'hC0200000, 32'hFFFFFFFE, 1'b0, 1'b0); // -2.5 -> -2
        send(0, 32'h40600000, 32'h00000004, 1'b0, 1'b0); // 3.5 -> 4
        send(0, 32'h3F000000, 32'h00000000, 1'b0, 1'b0); // 0.5 -> 0
        send(0, 32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0); // 2^31 saturates
        send(0, 32'hCF000000, 32'h80000000, 1'b0, 1'b0); // -2^31 legal
        send(0, 32'h7FC00000, 32'h80000000, 1'b0, 1'b1); // NaN
        send(0, 32'hFF800000, 32'h80000000, 1'b1, 1'b0); // -Inf
        send(0, 32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0); // +Inf
        send(0, 32'h00000001, 32'h00000000, 1'b0, 1'b0); // denormal
        send(0, 32'h80000000, 32'h00000000, 1'b0, 1'b0); // -0.0
        send(0, 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0); // largest below 2^31
        send(0, 32'h42F70000, 32'h0000007C, 1'b0, 1'b0); // 123.5 -> 124
        send(0, 32'h3F400000, 32'h00000001, 1'b0, 1'b0); // 0.75 -> 1
        send(0, 32'hBF000000, 32'h00000000, 1'b0, 1'b0); // -0.5 -> 0

        // Unsigned Q24.8 directed vectors
        send(1, 32'h3FC00000, 32'h00000180, 1'b0, 1'b0); // 1.5
        send(1, 32'hBF800000, 32'h00000000, 1'b1, 1'b0); // -1.0 clamps
        send(1, 32'h40200000, 32'h00000280, 1'b0, 1'b0); // 2.5
        send(1, 32'h4B800000, 32'hFFFFFFFF, 1'b1, 1'b0); // 2^24 saturates
        send(1, 32'hBA800000, 32'h00000000, 1'b0, 1'b0); // -2^-10 rounds to 0
        send(1, 32'h3B000000, 32'h00000000, 1'b0, 1'b0); // half LSB ties to even
        send(1, 32'h3BC00000, 32'h00000002, 1'b0, 1'b0); // 1.5 LSB -> 2
        send(1, 32'h7FC00000, 32'h00000000, 1'b0, 1'b1); // NaN
        send(1, 32'h80000000, 32'h00000000, 1'b0, 1'b0); // -0.0
        idle(8);

        // Back-to-back stream with a three-cycle clock-enable stall
        send(0, 32'h3F800000, 32'h00000001, 1'b0, 1'b0);
        send(0, 32'h40600000, 32'h00000004, 1'b0, 1'b0);
        send(0, 32'hC0200000, 32'hFFFFFFFE, 1'b0, 1'b0);
        send(0, 32'h42F70000, 32'h0000007C, 1'b0, 1'b0);
        send(0, 32'h40200000, 32'h00000002, 1'b0, 1'b0);
        send(0, 32'h3F400000, 32'h00000001, 1'b0, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        send(0, 32'hC0600000, 32'hFFFFFFFC, 1'b0, 1'b0); // -3.5 -> -4
        send(0, 32'h3FC00000, 32'h00000002, 1'b0, 1'b0); // 1.5 -> 2
        send(0, 32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0);
        idle(8);

        // Reset asserted while results are in flight and visible
        send(0, 32'h3F800000, 32'h00000001, 1'b0, 1'b0);
        send(0, 32'h40600000, 32'h00000004, 1'b0, 1'b0);
        send(0, 32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        send(0, 32'h7FC00000, 32'h80000000, 1'b0, 1'b1);
        send(0, 32'h3F800000, 32'h00000001, 1'b0, 1'b0);
        send(0, 32'h40600000, 32'h00000004, 1'b0, 1'b0);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midstream_reset_dut0", {29'd0, res0, vld0, ovf0, inv0}, 64'd0);
        chk("midstream_reset_dut1", {29'd0, res1, vld1, ovf1, inv1}, 64'd0);
        q0.delete();
        q1.delete();
        idle(2);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (vld0 || vld1) stale++;
        end
        chk("no_stale_valid", 64'(stale), 64'd0);

        // Pipe still functional after reset
        send(0, 32'hC0200000, 32'hFFFFFFFE, 1'b0, 1'b0);
        send(1, 32'h3FC00000, 32'h00000180, 1'b0, 1'b0);
        idle(10);

        chk("dut0_queue_drained", 64'(q0.size()), 64'd0);
        chk("dut1_queue_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
